// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encoding, default timeout length and word-alignment helpers.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Number of ACCESS cycles without dmem_ready before the bus is declared dead.
  localparam int DEFAULT_MAX_WAIT = 15;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // True when the byte address low bits select a whole word.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for a single bus transaction. Counts enabled cycles,
// is cleared between transactions and flags the cycle in which the
// MAX_WAIT-th enabled cycle is reached.
import mem_ctrl_pkg::*;

module mem_wait_timer #(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic timeout
);

  // Counter only has to reach MAX_WAIT-1; the timeout fires during that cycle.
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count;

  // Count enabled cycles, saturating at the last value so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // Timeout is qualified by enable so an idle counter never reports it.
  always_comb begin
    timeout = en && (count == LAST);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer. Turns the EX/MEM load/store
// controls into a held request toward a variable-latency memory, stalls the
// pipeline until the access completes and hands load data to MEM/WB.
// Optional performance counters are built when MEM_PERF_CNT_EN is defined.
import mem_ctrl_pkg::*;

module mem_access_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic              flush_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [DATA_W-1:0] wdata_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall_m,
  output logic [DATA_W-1:0] rdata_w,
  output logic              rdata_valid,
  output logic              misalign_err,
`ifdef MEM_PERF_CNT_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       mem_ops,
`endif
  output logic              bus_err
);

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic pending;
  logic start;
  logic latch_en;
  logic timer_en;
  logic timer_clr;
  logic timeout;

  // A squashed instruction never starts an access; misaligned ones are refused.
  always_comb begin
    pending = (mem_read_m | mem_write_m) & ~flush_m;
    start   = pending & is_word_aligned(addr_m[1:0]);
  end

  mem_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clr),
    .en     (timer_en),
    .timeout(timeout)
  );

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. The stall is raised combinationally in the
  // start cycle so the pipeline freezes before the instruction can move on.
  always_comb begin
    state_next   = state;
    stall_m      = 1'b0;
    dmem_req     = 1'b0;
    misalign_err = 1'b0;
    rdata_valid  = 1'b0;
    bus_err      = 1'b0;
    latch_en     = 1'b0;
    timer_en     = 1'b0;
    timer_clr    = 1'b0;
    case (state)
      IDLE: begin
        timer_clr = 1'b1;
        if (start) begin
          stall_m    = 1'b1;
          latch_en   = 1'b1;
          state_next = ACCESS;
        end else if (pending) begin
          misalign_err = 1'b1;
        end
      end
      ACCESS: begin
        dmem_req = 1'b1;
        stall_m  = 1'b1;
        timer_en = 1'b1;
        if (dmem_ready || timeout) begin
          state_next = DONE;
        end
      end
      DONE: begin
        timer_clr   = 1'b1;
        rdata_valid = ~we_q;
        bus_err     = err_q;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request at start so the bus stays stable while the pipeline
  // inputs are free to change. A combined read+write is treated as a store.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (latch_en) begin
      addr_q  <= addr_m;
      wdata_q <= wdata_m;
      we_q    <= mem_write_m;
    end
  end

  // Completion capture: ready beats a simultaneous timeout; a timeout zeroes
  // the load result and remembers the error for the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      if (dmem_ready) begin
        if (!we_q) begin
          rdata_q <= dmem_rdata;
        end
        err_q <= 1'b0;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Bus signals come only from the latched request, never from the pipeline.
  always_comb begin
    dmem_addr  = addr_q;
    dmem_wdata = wdata_q;
    dmem_we    = we_q & (state == ACCESS);
    rdata_w    = rdata_q;
  end

`ifdef MEM_PERF_CNT_EN
  // Performance counters: stalled cycles and completed accesses, free-wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      mem_ops      <= '0;
    end else begin
      if (stall_m) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if ((state == ACCESS) && (state_next == DONE)) begin
        mem_ops <= mem_ops + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes the expected outcome
// of each access, a monitor pops and compares when the DUT finishes one.
module tb_mem_access_ctrl;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_m, mem_write_m, flush_m;
  logic [31:0] addr_m, wdata_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        stall_m;
  logic [31:0] rdata_w;
  logic        rdata_valid, misalign_err, bus_err;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] stall_cycles, mem_ops;
`endif

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read_m  (mem_read_m),
    .mem_write_m (mem_write_m),
    .flush_m     (flush_m),
    .addr_m      (addr_m),
    .wdata_m     (wdata_m),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ready  (dmem_ready),
    .stall_m     (stall_m),
    .rdata_w     (rdata_w),
    .rdata_valid (rdata_valid),
    .misalign_err(misalign_err),
`ifdef MEM_PERF_CNT_EN
    .stall_cycles(stall_cycles),
    .mem_ops     (mem_ops),
`endif
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          misalign;
    int          stall_n;
    int          req_n;
    bit          rvalid;
    bit          chk_rdata;
    logic [31:0] rdata;
    bit          berr;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mkExp(bit mis, int sn, int rn, bit rv, bit chk, logic [31:0] rd,
                                 bit be, bit we, logic [31:0] a, logic [31:0] w);
    exp_t e;
    e.misalign = mis; e.stall_n = sn; e.req_n = rn; e.rvalid = rv; e.chk_rdata = chk;
    e.rdata = rd; e.berr = be; e.we = we; e.addr = a; e.wdata = w;
    return e;
  endfunction

  // Monitor state
  int          sn = 0, rn = 0;
  bit          prev_stall = 1'b0, seen = 1'b0, unstable = 1'b0, ev;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_we;
  exp_t        e;

  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (stall_m) sn++;
      if (dmem_req) begin
        if (!seen) begin
          seen = 1'b1; cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_we = dmem_we;
        end else if (cap_addr !== dmem_addr || cap_wdata !== dmem_wdata || cap_we !== dmem_we) begin
          unstable = 1'b1;
        end
        rn++;
      end
      ev = misalign_err || (prev_stall && !stall_m);
      if (ev) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_event: misalign=%0b stall_n=%0d req_n=%0d", misalign_err, sn, rn);
        end else begin
          e = exp_q.pop_front();
          checkOutput("misalign_err", 32'(misalign_err), 32'(e.misalign));
          checkOutput("stall_cycles", sn, e.stall_n);
          checkOutput("req_cycles", rn, e.req_n);
          checkOutput("rdata_valid", 32'(rdata_valid), 32'(e.rvalid));
          checkOutput("bus_err", 32'(bus_err), 32'(e.berr));
          if (e.chk_rdata) checkOutput("rdata_w", rdata_w, e.rdata);
          if (e.req_n > 0) begin
            checkOutput("dmem_we", 32'(cap_we), 32'(e.we));
            checkOutput("dmem_addr", cap_addr, e.addr);
            checkOutput("dmem_wdata", cap_wdata, e.wdata);
            checkOutput("bus_stable", 32'(unstable), 32'd0);
          end
        end
        sn = 0; rn = 0; seen = 1'b0; unstable = 1'b0;
      end else if (rdata_valid || bus_err) begin
        total++; bad++;
        $display("[TB] FAIL spurious_pulse: rdata_valid=%0b bus_err=%0b", rdata_valid, bus_err);
      end
      prev_stall = stall_m;
    end
  end

  // One aligned access: ready_at=k asserts dmem_ready in the k-th ACCESS
  // cycle, 0 means never. Optional flush or reset during ACCESS.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] w, input int ready_at,
                               input logic [31:0] rdv, input bit flush_mid,
                               input bit reset_mid);
    mem_read_m = rd; mem_write_m = wr; addr_m = a; wdata_m = w;
    @(posedge clk); #1;
    mem_read_m = 1'b0; mem_write_m = 1'b0; addr_m = 32'h0; wdata_m = 32'h0;
    if (flush_mid) begin flush_m = 1'b1; mem_read_m = 1'b1; end
    if (reset_mid) begin
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      return;
    end
    if (ready_at > 0) begin
      repeat (ready_at - 1) begin @(posedge clk); #1; end
      dmem_ready = 1'b1; dmem_rdata = rdv;
      @(posedge clk); #1;
      dmem_ready = 1'b0; dmem_rdata = 32'h0;
    end else begin
      repeat (MAX_WAIT) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    flush_m = 1'b0; mem_read_m = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_read_m = 1'b0; mem_write_m = 1'b0; flush_m = 1'b0;
    addr_m = 32'h0; wdata_m = 32'h0; dmem_rdata = 32'h0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("reset_stall_m", 32'(stall_m), 32'd0);
    checkOutput("reset_dmem_addr", dmem_addr, 32'd0);
    checkOutput("reset_rdata_w", rdata_w, 32'd0);
    checkOutput("reset_pulses", {29'd0, rdata_valid, bus_err, misalign_err}, 32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    $display("[TB] aligned load, ready on 3rd ACCESS cycle");
    exp_q.push_back(mkExp(0, 4, 3, 1, 1, 32'hDEADBEEF, 0, 0, 32'h100, 32'h0));
    applyStimulus(1, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, 0);

    $display("[TB] store, ready on 1st ACCESS cycle");
    exp_q.push_back(mkExp(0, 2, 1, 0, 0, 32'h0, 0, 1, 32'h204, 32'h12345678));
    applyStimulus(0, 1, 32'h204, 32'h12345678, 1, 32'h0, 0, 0);

    $display("[TB] misaligned load and store");
    exp_q.push_back(mkExp(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    mem_read_m = 1'b1; addr_m = 32'h102;
    @(posedge clk); #1; mem_read_m = 1'b0; addr_m = 32'h0;
    exp_q.push_back(mkExp(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0));
    mem_write_m = 1'b1; addr_m = 32'h205; wdata_m = 32'h55;
    @(posedge clk); #1; mem_write_m = 1'b0; addr_m = 32'h0; wdata_m = 32'h0;
    @(posedge clk); #1;

    $display("[TB] load with no ready -> timeout");
    exp_q.push_back(mkExp(0, MAX_WAIT + 1, MAX_WAIT, 1, 1, 32'h0, 1, 0, 32'h108, 32'h0));
    applyStimulus(1, 0, 32'h108, 32'h0, 0, 32'h0, 0, 0);

    $display("[TB] reset during 2nd ACCESS cycle");
    exp_q.push_back(mkExp(0, 3, 2, 0, 1, 32'h0, 0, 0, 32'h300, 32'h0));
    applyStimulus(1, 0, 32'h300, 32'h0, 0, 32'h0, 0, 1);
    @(negedge clk);
    checkOutput("post_reset_req", 32'(dmem_req), 32'd0);
    checkOutput("post_reset_stall", 32'(stall_m), 32'd0);
    checkOutput("post_reset_addr", dmem_addr, 32'd0);
    @(posedge clk); #1;

    $display("[TB] load after reset");
    exp_q.push_back(mkExp(0, 3, 2, 1, 1, 32'hA5A55A5A, 0, 0, 32'h400, 32'h0));
    applyStimulus(1, 0, 32'h400, 32'h0, 2, 32'hA5A55A5A, 0, 0);

    $display("[TB] flushed load in IDLE");
    mem_read_m = 1'b1; flush_m = 1'b1; addr_m = 32'h110;
    @(negedge clk);
    checkOutput("flush_idle_stall", 32'(stall_m), 32'd0);
    checkOutput("flush_idle_misalign", 32'(misalign_err), 32'd0);
    @(posedge clk); #1; mem_read_m = 1'b0; flush_m = 1'b0; addr_m = 32'h0;
    @(negedge clk);
    checkOutput("flush_idle_req", 32'(dmem_req), 32'd0);

    $display("[TB] ready outside ACCESS is ignored");
    @(posedge clk); #1; dmem_ready = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    @(negedge clk);
    checkOutput("idle_ready_rdata_w", rdata_w, 32'hA5A55A5A);
    @(posedge clk); #1;

    $display("[TB] flush asserted mid-ACCESS");
    exp_q.push_back(mkExp(0, 3, 2, 1, 1, 32'h0BADF00D, 0, 0, 32'h10C, 32'h0));
    applyStimulus(1, 0, 32'h10C, 32'h0, 2, 32'h0BADF00D, 1, 0);

    $display("[TB] read and write together act as store");
    exp_q.push_back(mkExp(0, 2, 1, 0, 1, 32'h0BADF00D, 0, 1, 32'h208, 32'hCAFEF00D));
    applyStimulus(1, 1, 32'h208, 32'hCAFEF00D, 1, 32'h11111111, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a run that never reaches its summary.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
